// File: rtl/alu_ctrl_decode.sv
// Registered RV32I decode stage feeding ALU control, register indices and datapath enables.
// Optional macro ALU_CTRL_DECODE_STATS_EN adds stat_decoded/stat_illegal transfer counters.
module alu_ctrl_decode #(
   parameter int XLEN      = 32,
   parameter bit RESET_NOP = 1'b1
) (
   input  logic            clock,
   input  logic            reset,
   input  logic [31:0]     in_instr,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      aluoper,
   output logic            selopr2,
   output logic [XLEN-1:0] dataimmed,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic            regwrite,
   output logic            memread,
   output logic            memwrite,
   output logic            branch,
   output logic            jump,
   output logic [2:0]      brfunct3,
   output logic            illegal,
`ifdef ALU_CTRL_DECODE_STATS_EN
   output logic [31:0]     stat_decoded,
   output logic [31:0]     stat_illegal,
`endif
   output logic            trap
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_XOR  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_AND  = 4'b0100;
   localparam logic [3:0] ALU_SLL  = 4'b0101;
   localparam logic [3:0] ALU_SRL  = 4'b0110;
   localparam logic [3:0] ALU_SRA  = 4'b0111;
   localparam logic [3:0] ALU_SLT  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;

   typedef struct packed {
      logic [3:0]  aluoper;
      logic        selopr2;
      logic [31:0] dataimmed;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        regwrite;
      logic        memread;
      logic        memwrite;
      logic        branch;
      logic        jump;
      logic [2:0]  brfunct3;
      logic        illegal;
   } fields_t;

   state_t  state_reg, state_next;
   logic    out_valid_reg, out_valid_next;
   fields_t fields_reg, dec, reset_fields;
   logic    legal, accept, xfer_out;

   logic [6:0]  opcode;
   logic [2:0]  funct3;
   logic [6:0]  funct7;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sh;

   assign opcode = in_instr[6:0];
   assign funct3 = in_instr[14:12];
   assign funct7 = in_instr[31:25];
   assign imm_i  = {{20{in_instr[31]}}, in_instr[31:20]};
   assign imm_s  = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign imm_b  = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0};
   assign imm_u  = {in_instr[31:12], 12'b0};
   assign imm_j  = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0};
   assign imm_sh = {27'b0, in_instr[24:20]};

   always_comb begin
      reset_fields         = '0;
      reset_fields.selopr2 = RESET_NOP;
   end

   always_comb begin
      dec      = '0;
      legal    = 1'b1;
      dec.rs1  = in_instr[19:15];
      dec.rs2  = in_instr[24:20];
      dec.rd   = in_instr[11:7];
      case (opcode)
         OPC_OP: begin
            dec.regwrite = 1'b1;
            case (funct3)
               3'b000:  dec.aluoper = funct7[5] ? ALU_SUB : ALU_ADD;
               3'b100:  dec.aluoper = ALU_XOR;
               3'b110:  dec.aluoper = ALU_OR;
               3'b111:  dec.aluoper = ALU_AND;
               3'b001:  dec.aluoper = ALU_SLL;
               3'b101:  dec.aluoper = funct7[5] ? ALU_SRA : ALU_SRL;
               3'b010:  dec.aluoper = ALU_SLT;
               default: dec.aluoper = ALU_SLTU;
            endcase
            // Only sub/sra may carry funct7=0100000; everything else needs all-zero funct7.
            if (funct7 == 7'b0100000) begin
               if (funct3 != 3'b000 && funct3 != 3'b101) legal = 1'b0;
            end else if (funct7 != 7'b0000000) begin
               legal = 1'b0;
            end
         end
         OPC_OPIMM: begin
            dec.selopr2   = 1'b1;
            dec.regwrite  = 1'b1;
            dec.dataimmed = imm_i;
            case (funct3)
               3'b000:  dec.aluoper = ALU_ADD;
               3'b010:  dec.aluoper = ALU_SLT;
               3'b011:  dec.aluoper = ALU_SLTU;
               3'b100:  dec.aluoper = ALU_XOR;
               3'b110:  dec.aluoper = ALU_OR;
               3'b111:  dec.aluoper = ALU_AND;
               3'b001:  dec.aluoper = ALU_SLL;
               default: dec.aluoper = in_instr[30] ? ALU_SRA : ALU_SRL;
            endcase
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec.dataimmed = imm_sh;
               if (in_instr[31] || (in_instr[29:25] != 5'b0)) legal = 1'b0;
            end
         end
         OPC_LOAD: begin
            dec.selopr2   = 1'b1;
            dec.dataimmed = imm_i;
            dec.memread   = 1'b1;
            dec.regwrite  = 1'b1;
         end
         OPC_STORE: begin
            dec.selopr2   = 1'b1;
            dec.dataimmed = imm_s;
            dec.memwrite  = 1'b1;
            dec.rd        = 5'd0;
         end
         OPC_BRANCH: begin
            dec.dataimmed = imm_b;
            dec.branch    = 1'b1;
            dec.brfunct3  = funct3;
            dec.rd        = 5'd0;
            case (funct3[2:1])
               2'b00:   dec.aluoper = ALU_SUB;
               2'b10:   dec.aluoper = ALU_SLT;
               2'b11:   dec.aluoper = ALU_SLTU;
               default: legal = 1'b0;
            endcase
         end
         OPC_LUI: begin
            dec.selopr2   = 1'b1;
            dec.rs1       = 5'd0;
            dec.dataimmed = imm_u;
            dec.regwrite  = 1'b1;
         end
         OPC_AUIPC: begin
            dec.selopr2   = 1'b1;
            dec.dataimmed = imm_u;
            dec.regwrite  = 1'b1;
         end
         OPC_JAL: begin
            dec.selopr2   = 1'b1;
            dec.dataimmed = imm_j;
            dec.jump      = 1'b1;
            dec.regwrite  = 1'b1;
         end
         OPC_JALR: begin
            dec.selopr2   = 1'b1;
            dec.dataimmed = imm_i;
            dec.jump      = 1'b1;
            dec.regwrite  = 1'b1;
         end
         default: legal = 1'b0;
      endcase
      if (in_instr[1:0] != 2'b11) legal = 1'b0;
      // Illegal words are still passed down, but stripped of every field and enable.
      if (!legal) begin
         dec         = '0;
         dec.illegal = 1'b1;
      end
   end

   assign xfer_out = out_valid_reg && out_ready && !flush;
   assign in_ready = (state_reg == RUN) && (!out_valid_reg || out_ready) && !flush;
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_next     = state_reg;
      out_valid_next = out_valid_reg;
      if (flush) begin
         state_next     = RUN;
         out_valid_next = 1'b0;
      end else begin
         if (xfer_out && fields_reg.illegal) state_next = TRAP;
         if (accept)        out_valid_next = 1'b1;
         else if (xfer_out) out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg     <= RUN;
         out_valid_reg <= 1'b0;
         fields_reg    <= reset_fields;
      end else begin
         state_reg     <= state_next;
         out_valid_reg <= out_valid_next;
         if (accept) fields_reg <= dec;
      end
   end

`ifdef ALU_CTRL_DECODE_STATS_EN
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         stat_decoded <= '0;
         stat_illegal <= '0;
      end else if (xfer_out) begin
         stat_decoded <= stat_decoded + 32'd1;
         if (fields_reg.illegal) stat_illegal <= stat_illegal + 32'd1;
      end
   end
`else
   // Statistics counters are not built in this configuration.
`endif

   assign out_valid = out_valid_reg;
   assign trap      = (state_reg == TRAP);
   assign aluoper   = fields_reg.aluoper;
   assign selopr2   = fields_reg.selopr2;
   assign dataimmed = fields_reg.dataimmed;
   assign rs1       = fields_reg.rs1;
   assign rs2       = fields_reg.rs2;
   assign rd        = fields_reg.rd;
   assign regwrite  = fields_reg.regwrite;
   assign memread   = fields_reg.memread;
   assign memwrite  = fields_reg.memwrite;
   assign branch    = fields_reg.branch;
   assign jump      = fields_reg.jump;
   assign brfunct3  = fields_reg.brfunct3;
   assign illegal   = fields_reg.illegal;

endmodule

// File: doc/alu_ctrl_decode.md
Name: alu_ctrl_decode

Overview:
- Registered instruction-decode stage for the tiny RISC-V CPU (RV32I base, no CSR/FENCE).
- Drives the ALU control side: aluoper, selopr2, dataimmed, plus register indices and datapath enables.
- Sits between instruction fetch and the ALU/regfile.
- Valid/ready on both sides, one-entry output register, flush for taken branches, sticky trap on illegal opcodes.

Parameters:
- XLEN, 32, datapath/immediate width (only 32 supported)
- RESET_NOP, 1, 1: output register holds decoded NOP (addi x0,x0,0) after reset; 0: holds all-zero

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_instr  input  32  instruction word
- in_valid  input  1  in_instr valid
- in_ready  output  1  stage can accept in_instr
- flush  input  1  discard held output; clears trap
- out_valid  output  1  decoded fields valid
- out_ready  input  1  downstream accepts decoded fields
- aluoper  output  4  ALU op code: 0000 add, 0001 sub, 0010 xor, 0011 or, 0100 and, 0101 sll, 0110 srl, 0111 sra, 1000 slt, 1001 sltu
- selopr2  output  1  0: operand2 = rs2 data; 1: operand2 = dataimmed
- dataimmed  output  32  generated immediate
- rs1, rs2, rd  output  5 each  register indices
- regwrite, memread, memwrite, branch, jump  output  1 each  datapath enables
- brfunct3  output  3  funct3 of a branch (else 0)
- illegal  output  1  held instruction is illegal
- trap  output  1  sticky illegal-instruction state

Behaviour:
- Reset (async, immediate):
  - state=RUN, out_valid=0, trap=0, illegal=0.
  - RESET_NOP=1: aluoper=0000, selopr2=1, all other fields 0. RESET_NOP=0: all fields 0.
- Handshake:
  - in_ready = (state==RUN) && (!out_valid || out_ready).
  - Transfer on in_valid && in_ready. Decoded fields register on the same edge; out_valid=1 next cycle; latency 1.
  - Fields hold stable while out_valid && !out_ready. Full throughput, no bubbles, when out_ready stays high.
- Decode (rd/rs1/rs2 from bits 11:7/19:15/24:20 unless stated):
  - OP (0110011): selopr2=0, regwrite=1.
    - funct3/funct7[5] map: 000/0 add, 000/1 sub, 100 xor, 110 or, 111 and, 001 sll, 101/0 srl, 101/1 sra, 010 slt, 011 sltu.
    - Any other funct7 is illegal.
  - OP-IMM (0010011): selopr2=1, regwrite=1, I-immediate sign-extended. ADDI always uses 0000, never 0001.
  - Shifts SLLI/SRLI/SRAI: dataimmed = zero-extended instr[24:20]. instr[30] selects 0111 for SRAI. Nonzero instr[31,29:25] is illegal.
  - LOAD (0000011): aluoper=0000, selopr2=1, I-imm, memread=1, regwrite=1.
  - STORE (0100011): aluoper=0000, selopr2=1, S-imm, memwrite=1, rd=0.
  - BRANCH (1100011): selopr2=0, B-imm, branch=1, brfunct3=funct3, rd=0.
    - BEQ/BNE use 0001; BLT/BGE use 1000; BLTU/BGEU use 1001. funct3 010/011 is illegal.
  - LUI: aluoper=0000, selopr2=1, rs1 forced 0, U-imm, regwrite=1.
  - AUIPC/JAL/JALR: aluoper=0000, selopr2=1, jump=1 (except AUIPC), regwrite=1. U/J/I immediate respectively.
  - Any other opcode, or instr[1:0]!=11, is illegal.
- Illegal handling:
  - Illegal instruction is accepted and presented with illegal=1 and all enables 0.
  - On its transfer out, state goes to TRAP and trap=1. in_ready=0 while in TRAP.
- Flush:
  - Clears out_valid the next edge and discards any simultaneous input transfer (in_ready forced 0 while flush=1).
  - Returns TRAP to RUN and clears trap. Flush has priority over out_ready and in_valid.
- Reset mid-operation: any held instruction is lost, no transfer completes.

Optional Feature:
- Macro ALU_CTRL_DECODE_STATS_EN.
- Defined: adds outputs stat_decoded (32) and stat_illegal (32).
  - stat_decoded counts output transfers (out_valid && out_ready && !flush); stat_illegal counts those with illegal=1.
  - Both wrap at 2^32 and reset to 0.
- Undefined: ports and counters absent; no other behaviour change.

Test Plan:
- Reset released, no input -> out_valid=0, in_ready=1, aluoper=0000, selopr2=1 (RESET_NOP=1).
- Stream 0x002081B3 (add x3,x1,x2) then 0x402081B3 (sub), out_ready=1 -> next cycles aluoper 0000 then 0001, selopr2=0, rd=3, rs1=1, rs2=2, regwrite=1, one per cycle.
- 0x4050D193 (srai x3,x1,5) -> aluoper=0111, selopr2=1, dataimmed=0x00000005. Then 0xFFF00093 (addi x1,x0,-1) -> aluoper=0000, dataimmed=0xFFFFFFFF.
- 0xFE20CEE3 (blt x1,x2,-4) with out_ready=0 for 3 cycles -> aluoper=1000, dataimmed=0xFFFFFFFC, branch=1 held stable, in_ready=0; released after out_ready=1.
- 0x00000000 accepted -> illegal=1, after transfer trap=1, in_ready=0. Pulse flush -> trap=0, in_ready=1. STATS_EN: stat_illegal=1.
- flush asserted with out_valid=1 and in_valid=1 -> out_valid=0 next cycle, input not consumed, stat_decoded unchanged.
